// File: rtl/data_mem_adapter.sv
// ---------------------------------------------------------------------------
// data_mem_adapter
//
// Bridges the load/store unit's memory-request port to a single-port 32-bit
// synchronous data RAM with one cycle of read latency.
//  * Stores: the left-justified lane mask and data are steered to the lanes
//    selected by the byte offset and written in the accept cycle.
//  * Loads: the RAM is read in the accept cycle. The addressed bytes are
//    extracted on the following cycle, right-justified and zero-extended,
//    then queued in an in-order response FIFO that has registered outputs.
//  * Illegal or misaligned requests pulse misalign_error for one cycle. Such
//    a request never touches the RAM. A request that asks for read data
//    still gets a response, with data 0, so the requester never waits
//    forever on a tag.
//
// Bit numbering follows the LSU convention: bit 0 is the MSB, and byte lane
// 0 is bits [0:7].
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   to_mem_*            request channel (valid/ready), tag, destination register
//   mem_address         byte address; [30:31] = byte offset
//   mem_write_en/data   left-justified store lane mask / store data
//   mem_read_en         left-justified load lane mask
//   from_mem_*          response channel (valid/ready), tag, destination register
//   mem_read_data       right-justified, zero-extended load data
//   misalign_error      one-cycle pulse when an illegal/misaligned request is accepted
//   ram_en/we/addr/wdata  RAM request (the lane enables of ram_we are bits [0:3])
//   ram_rdata           RAM read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module data_mem_adapter #(
  parameter int RS_ID_WIDTH = 5,
  parameter int RAM_AW      = 10,
  parameter int RESP_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   to_mem_valid,
  output logic                   to_mem_ready,
  input  logic [RS_ID_WIDTH-1:0] to_mem_rs_id,
  input  logic [4:0]             to_mem_reg_addr,
  input  logic [0:31]            mem_address,
  input  logic [0:3]             mem_write_en,
  input  logic [0:31]            mem_write_data,
  input  logic [0:3]             mem_read_en,
  output logic                   from_mem_valid,
  input  logic                   from_mem_ready,
  output logic [RS_ID_WIDTH-1:0] from_mem_rs_id,
  output logic [4:0]             from_mem_reg_addr,
  output logic [0:31]            mem_read_data,
  output logic                   misalign_error,
  output logic                   ram_en,
  output logic [0:3]             ram_we,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [0:31]            ram_wdata,
  input  logic [0:31]            ram_rdata
);

  localparam int CW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             reg_addr;
    logic [0:31]            data;
  } resp_t;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  function automatic logic [2:0] mask_size(input logic [0:3] m);
    case (m)
      4'b1000: return 3'd1;
      4'b1100: return 3'd2;
      4'b1111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  logic [1:0] req_off;
  logic [2:0] wr_size;
  logic [2:0] rd_size;
  logic [3:0] wr_end;
  logic [3:0] rd_end;
  logic       has_wr;
  logic       has_rd;
  logic       store_ok;
  logic       load_ok;
  logic       req_err;

  always_comb begin
    req_off  = mem_address[30:31];
    has_wr   = |mem_write_en;
    has_rd   = |mem_read_en;
    wr_size  = mask_size(mem_write_en);
    rd_size  = mask_size(mem_read_en);
    wr_end   = {2'b00, req_off} + {1'b0, wr_size};
    rd_end   = {2'b00, req_off} + {1'b0, rd_size};
    store_ok = has_wr && !has_rd && (wr_size != 3'd0) && (wr_end <= 4'd4);
    load_ok  = has_rd && !has_wr && (rd_size != 3'd0) && (rd_end <= 4'd4);
    req_err  = (has_wr || has_rd) && !store_ok && !load_ok;
  end

  logic rdy_q;
  logic rdy_d;
  logic accept;
  logic resp_acc;

  assign accept   = to_mem_valid && rdy_q;
  // Anything that asks for read data occupies a response slot, even when it is illegal.
  assign resp_acc = accept && has_rd;

  // The RAM request is combinational from the accepted request. It is forced
  // to zero otherwise, so the RAM pins stay quiet when the RAM is idle.
  always_comb begin
    ram_en         = accept && (store_ok || load_ok);
    ram_we         = '0;
    ram_wdata      = '0;
    ram_addr       = '0;
    misalign_error = accept && req_err;
    if (accept && store_ok) begin
      ram_we    = mem_write_en >> req_off;
      ram_wdata = mem_write_data >> {req_off, 3'b000};
    end
    if (ram_en) begin
      ram_addr = mem_address[30-RAM_AW:29];
    end
  end

  // Address bits above the RAM window do not select anything.
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_address[0:29-RAM_AW];

  // -------------------------------------------------------------------------
  // In-flight slot: one load whose RAM data returns this cycle
  // -------------------------------------------------------------------------
  logic                   infl_valid_q, infl_valid_d;
  logic                   infl_ok_q,    infl_ok_d;
  logic [1:0]             infl_off_q,   infl_off_d;
  logic [2:0]             infl_size_q,  infl_size_d;
  logic [RS_ID_WIDTH-1:0] infl_rs_id_q, infl_rs_id_d;
  logic [4:0]             infl_reg_q,   infl_reg_d;

  always_comb begin
    infl_valid_d = resp_acc;
    infl_ok_d    = load_ok;
    infl_off_d   = req_off;
    infl_size_d  = rd_size;
    infl_rs_id_d = to_mem_rs_id;
    infl_reg_d   = to_mem_reg_addr;
  end

  // Shift the addressed bytes up to lane 0, then down so that the last byte
  // lands in the low lane. Zeros fill in from both shifts.
  logic [0:31] rd_aligned;
  logic [2:0]  drop_bytes;
  resp_t       push_ent;

  always_comb begin
    rd_aligned        = ram_rdata << {infl_off_q, 3'b000};
    drop_bytes        = 3'd4 - infl_size_q;
    push_ent.rs_id    = infl_rs_id_q;
    push_ent.reg_addr = infl_reg_q;
    push_ent.data     = infl_ok_q ? (rd_aligned >> {drop_bytes, 3'b000}) : '0;
  end

  // -------------------------------------------------------------------------
  // Response FIFO: entry 0 is the head and drives the outputs directly
  // -------------------------------------------------------------------------
  resp_t         fifo_q [RESP_DEPTH];
  resp_t         fifo_d [RESP_DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wr_idx;
  logic          valid_q, valid_d;
  logic          push;
  logic          pop;
  logic [CW:0]   pend_d;

  assign push = infl_valid_q;
  assign pop  = valid_q && from_mem_ready;

  always_comb begin
    wr_idx = cnt_q - CW'(pop);
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    for (int i = 0; i < RESP_DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
      // The tail entry vacated by a pop is don't-care, so the modulo wrap is harmless.
      if (pop) begin
        fifo_d[i] = fifo_q[(i + 1) % RESP_DEPTH];
      end
      if (push && (wr_idx == CW'(i))) begin
        fifo_d[i] = push_ent;
      end
    end
    valid_d = (cnt_d != '0);
    // Pending counts both queued responses and the load in flight. Ready is
    // derived from next-state registers only, so it never depends
    // combinationally on to_mem_valid or from_mem_ready.
    pend_d = {1'b0, cnt_d} + {{CW{1'b0}}, infl_valid_d};
    rdy_d  = (int'(pend_d) < RESP_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q        <= 1'b0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      infl_valid_q <= 1'b0;
      infl_ok_q    <= 1'b0;
      infl_off_q   <= '0;
      infl_size_q  <= '0;
      infl_rs_id_q <= '0;
      infl_reg_q   <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rdy_q        <= rdy_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      infl_valid_q <= infl_valid_d;
      infl_ok_q    <= infl_ok_d;
      infl_off_q   <= infl_off_d;
      infl_size_q  <= infl_size_d;
      infl_rs_id_q <= infl_rs_id_d;
      infl_reg_q   <= infl_reg_d;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign to_mem_ready      = rdy_q;
  assign from_mem_valid    = valid_q;
  assign from_mem_rs_id    = fifo_q[0].rs_id;
  assign from_mem_reg_addr = fifo_q[0].reg_addr;
  assign mem_read_data     = fifo_q[0].data;

endmodule

// File: tb/tb_data_mem_adapter.sv
// ---------------------------------------------------------------------------
// Bench for data_mem_adapter. A byte-addressed shadow memory plus a queue of
// expected responses predict every output cycle by cycle. A simple word RAM
// with one cycle of read latency stands in for the data RAM.
// ---------------------------------------------------------------------------
module tb_data_mem_adapter;

  localparam int RSW   = 5;
  localparam int AW    = 10;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            to_mem_valid = 1'b0;
  logic            to_mem_ready;
  logic [RSW-1:0]  to_mem_rs_id = '0;
  logic [4:0]      to_mem_reg_addr = '0;
  logic [0:31]     mem_address = '0;
  logic [0:3]      mem_write_en = '0;
  logic [0:31]     mem_write_data = '0;
  logic [0:3]      mem_read_en = '0;
  logic            from_mem_valid;
  logic            from_mem_ready = 1'b1;
  logic [RSW-1:0]  from_mem_rs_id;
  logic [4:0]      from_mem_reg_addr;
  logic [0:31]     mem_read_data;
  logic            misalign_error;
  logic            ram_en;
  logic [0:3]      ram_we;
  logic [AW-1:0]   ram_addr;
  logic [0:31]     ram_wdata;
  bit   [0:31]     ram_rdata;

  data_mem_adapter #(.RS_ID_WIDTH(RSW), .RAM_AW(AW), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .to_mem_valid(to_mem_valid), .to_mem_ready(to_mem_ready),
    .to_mem_rs_id(to_mem_rs_id), .to_mem_reg_addr(to_mem_reg_addr),
    .mem_address(mem_address), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
    .from_mem_valid(from_mem_valid), .from_mem_ready(from_mem_ready),
    .from_mem_rs_id(from_mem_rs_id), .from_mem_reg_addr(from_mem_reg_addr),
    .mem_read_data(mem_read_data), .misalign_error(misalign_error),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM standing in for the data RAM: synchronous read, per-lane write.
  bit [0:31] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) begin
        ram_rdata <= ram_mem[ram_addr];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (ram_we[i]) ram_mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Reference model state
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rg;
    int          avail;
  } exp_t;

  exp_t     exp_q[$];
  bit [7:0] bmem [0:255];
  int       n_cmp = 0;
  int       n_bad = 0;
  int       cyc = 0;
  int       pend = 0;
  int       resp_cnt = 0;
  bit       ready_ok = 1'b0;
  bit       last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int size_of(input logic [0:3] m);
    if (m == 4'b1000) return 1;
    if (m == 4'b1100) return 2;
    if (m == 4'b1111) return 4;
    return 0;
  endfunction

  // One clock cycle: check every output against the model at the negedge,
  // then let the model advance past the posedge.
  task automatic do_cycle();
    int a, o, n_w, n_r, lane;
    bit st_ok, ld_ok, err, acc, pop, exp_v;
    int unsigned wd, b, v, exp_we, exp_wd, wmask;
    exp_t e;
    @(negedge clk);
    a     = int'(mem_address & 32'h0000_00FF);
    o     = a % 4;
    n_w   = size_of(mem_write_en);
    n_r   = size_of(mem_read_en);
    st_ok = (mem_write_en != 0) && (mem_read_en == 0) && (n_w != 0) && (o + n_w <= 4);
    ld_ok = (mem_read_en != 0) && (mem_write_en == 0) && (n_r != 0) && (o + n_r <= 4);
    err   = ((mem_write_en != 0) || (mem_read_en != 0)) && !st_ok && !ld_ok;
    acc   = to_mem_valid && to_mem_ready;

    chk("to_mem_ready", to_mem_ready, ready_ok && (pend < DEPTH));
    chk("misalign_error", misalign_error, acc && err);
    chk("ram_en", ram_en, acc && (st_ok || ld_ok));

    exp_we = 0; exp_wd = 0; wmask = 0;
    wd = mem_write_data;
    if (acc && st_ok) begin
      for (int k = 0; k < n_w; k++) begin
        lane   = o + k;
        b      = (wd >> (8 * (3 - k))) & 32'hFF;
        exp_we = exp_we | (32'd8 >> lane);
        exp_wd = exp_wd | (b << (8 * (3 - lane)));
        wmask  = wmask | (32'hFF << (8 * (3 - lane)));
        bmem[a + k] = b[7:0];
      end
    end
    chk("ram_we", ram_we, exp_we);
    if (acc && st_ok) chk("ram_wdata", ram_wdata & wmask, exp_wd);
    if (acc && (st_ok || ld_ok)) chk("ram_addr", ram_addr, a / 4);

    exp_v = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
    chk("from_mem_valid", from_mem_valid, exp_v);
    if (exp_v && from_mem_valid) begin
      chk("resp_data", mem_read_data, exp_q[0].data);
      chk("resp_rs_id", from_mem_rs_id, exp_q[0].rs);
      chk("resp_reg", from_mem_reg_addr, exp_q[0].rg);
    end
    pop = from_mem_valid && from_mem_ready;
    if (pop) begin
      resp_cnt++;
      $display("[%0d] resp rs=%0d reg=%0d data=%h", cyc, from_mem_rs_id, from_mem_reg_addr, mem_read_data);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pend--;
    end

    if (acc) begin
      $display("[%0d] req  addr=%h we=%b re=%b wd=%h rs=%0d", cyc, mem_address, mem_write_en,
               mem_read_en, mem_write_data, to_mem_rs_id);
    end
    if (acc && (mem_read_en != 0)) begin
      v = 0;
      if (ld_ok) begin
        for (int k = 0; k < n_r; k++) v = (v << 8) | 32'(bmem[a + k]);
      end
      e.data  = v;
      e.rs    = to_mem_rs_id;
      e.rg    = to_mem_reg_addr;
      e.avail = cyc + 2;
      exp_q.push_back(e);
      pend++;
    end
    last_acc = acc;
    @(posedge clk);
    ready_ok = !rst;
    cyc++;
    #1;
  endtask

  task automatic set_req(input logic v, input logic [0:3] we, input logic [31:0] wdat,
                         input logic [0:3] re, input int addr, input int rs, input int rg);
    to_mem_valid    = v;
    mem_write_en    = we;
    mem_write_data  = wdat;
    mem_read_en     = re;
    mem_address     = 32'(addr);
    to_mem_rs_id    = RSW'(rs);
    to_mem_reg_addr = 5'(rg);
  endtask

  task automatic send(input logic [0:3] we, input logic [31:0] wdat, input logic [0:3] re,
                      input int addr, input int rs, input int rg);
    bit done;
    done = 1'b0;
    set_req(1'b1, we, wdat, re, addr, rs, rg);
    for (int t = 0; t < 20 && !done; t++) begin
      do_cycle();
      done = last_acc;
    end
    chk("accept_timeout", done, 1'b1);
    to_mem_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    to_mem_valid = 1'b0;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  task automatic rnd_req();
    int k, r;
    logic [0:3] lm, we, re;
    k  = $urandom_range(0, 9);
    r  = $urandom_range(0, 2);
    lm = (r == 0) ? 4'b1000 : (r == 1) ? 4'b1100 : 4'b1111;
    we = '0;
    re = '0;
    case (k)
      1, 2, 3:    we = lm;
      4, 5, 6, 7: re = lm;
      8: begin
        if ($urandom_range(0, 1) == 0) we = 4'($urandom);
        else re = 4'($urandom);
      end
      9: begin
        we = lm;
        re = lm;
      end
      default: ;
    endcase
    set_req($urandom_range(0, 3) != 0, we, $urandom, re, $urandom_range(0, 63),
            $urandom_range(0, 31), $urandom_range(0, 31));
  endtask

  int base;

  initial begin
    // Reset state
    #1;
    chk("rst_ready", to_mem_ready, 1'b0);
    chk("rst_valid", from_mem_valid, 1'b0);
    chk("rst_data", mem_read_data, 32'h0);
    idle(3);
    rst = 1'b0;
    idle(2);

    // Full-word store then load
    send(4'b1111, 32'h1122_3344, 4'b0000, 0, 1, 2);
    send(4'b0000, 32'h0, 4'b1111, 0, 3, 4);
    idle(4);

    // Byte store at offset 3 and reload
    send(4'b1000, 32'hAB00_0000, 4'b0000, 7, 5, 6);
    send(4'b0000, 32'h0, 4'b1000, 7, 7, 8);
    idle(4);

    // Halfword loads from both halves
    send(4'b0000, 32'h0, 4'b1100, 2, 9, 10);
    send(4'b0000, 32'h0, 4'b1100, 0, 11, 12);
    idle(4);

    // Backpressure: third load held until responses drain
    base = resp_cnt;
    from_mem_ready = 1'b0;
    send(4'b0000, 32'h0, 4'b1111, 0, 13, 1);
    send(4'b0000, 32'h0, 4'b1000, 7, 14, 2);
    set_req(1'b1, 4'b0000, 32'h0, 4'b1100, 2, 15, 3);
    for (int i = 0; i < 4; i++) begin
      do_cycle();
      chk("third_held", last_acc, 1'b0);
    end
    from_mem_ready = 1'b1;
    for (int i = 0; i < 10 && !last_acc; i++) do_cycle();
    chk("third_accepted", last_acc, 1'b1);
    idle(6);
    chk("resp_count", resp_cnt - base, 3);

    // Misaligned load and store; memory must be unchanged afterwards
    send(4'b0000, 32'h0, 4'b1100, 3, 16, 17);
    send(4'b1111, 32'hDEAD_BEEF, 4'b0000, 1, 18, 19);
    send(4'b0000, 32'h0, 4'b1111, 0, 20, 21);
    idle(4);

    // Reset with two loads pending
    from_mem_ready = 1'b0;
    send(4'b0000, 32'h0, 4'b1111, 0, 22, 1);
    send(4'b0000, 32'h0, 4'b1111, 4, 23, 2);
    idle(1);
    rst = 1'b1;
    ready_ok = 1'b0;
    #1;
    chk("async_rst_valid", from_mem_valid, 1'b0);
    chk("async_rst_ready", to_mem_ready, 1'b0);
    chk("async_rst_data", mem_read_data, 32'h0);
    exp_q.delete();
    pend = 0;
    idle(2);
    rst = 1'b0;
    from_mem_ready = 1'b1;
    idle(6);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rnd_req();
      from_mem_ready = ($urandom_range(0, 3) != 0);
      do_cycle();
    end
    from_mem_ready = 1'b1;
    idle(10);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
